video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL provide these parameters:
- H_ACTIVE, default 320, active pixels per line.
- H_FP, default 16, horizontal front porch in pixels.
- H_SYNC, default 32, horizontal sync width in pixels.
- H_BP, default 40, horizontal back porch in pixels.
- V_ACTIVE, default 240, active lines.
- V_FP, default 3, vertical front porch in lines.
- V_SYNC, default 3, vertical sync width in lines.
- V_BP, default 16, vertical back porch in lines.
- COLOR_DEPTH, default 6, width of each colour output, 1-8.

REQ-002 SHALL provide these ports, clock and reset first:
- clk_sys  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce_divider  in  3  pixel clock-enable divide select.
- ce_pix  out  1  one-cycle pixel clock-enable pulse.
- hcount  out  10  pixel counter, 0..H_TOTAL-1.
- vcount  out  10  line counter, 0..V_TOTAL-1.
- HSync, VSync  out  1 each  active-low syncs.
- HBlank, VBlank  out  1 each  active-high blanks.
- DE  out  1  ~(HBlank|VBlank).
- frame_start  out  1  one-cycle pulse at (0,0).
- R, G, B  out  COLOR_DEPTH each  pixel data.

REQ-003 SHALL drive all outputs from registers; no combinational input-to-output paths.

Function
REQ-004 Totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL be <= 1024.

REQ-005 The divide ratio N SHALL be 4 when ce_divider=0, otherwise ce_divider+1 (range 2..8).

REQ-006 ce_pix SHALL pulse for exactly one clk_sys cycle, once every N cycles, from a free-running divide counter.

REQ-007 ce_divider SHALL be sampled only at the ce_pix where hcount wraps to 0; a mid-line change SHALL take effect from the next line start; the pulse spacing within a line SHALL never be irregular.

REQ-008 On each clock edge with ce_pix=1, hcount SHALL increment.

REQ-009 At H_TOTAL-1, hcount SHALL wrap to 0 and vcount SHALL increment; at V_TOTAL-1, vcount SHALL wrap to 0.

REQ-010 Between ce_pix pulses, all outputs SHALL hold their values.

REQ-011 HBlank, HSync, VBlank, VSync, DE and R/G/B SHALL update on the same edge as the counters and SHALL describe the new hcount/vcount, i.e. zero relative latency.

REQ-012 HBlank SHALL be 1 iff hcount >= H_ACTIVE.

REQ-013 HSync SHALL be 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.

REQ-014 VBlank SHALL be 1 iff vcount >= V_ACTIVE.

REQ-015 VSync SHALL be 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; VSync SHALL change only on the edge where hcount becomes 0.

REQ-016 frame_start SHALL be 1 for exactly the single clk_sys cycle following the edge that sets hcount=0 and vcount=0.

Reset
REQ-017 While reset_n=0, the block SHALL hold the following values: ce_pix=0, divide counter=0, hcount=0, vcount=0, HSync=1, VSync=1, HBlank=0, VBlank=0, DE=1, frame_start=0, R=G=B=0.

REQ-018 The latched N SHALL take the value of ce_divider sampled at the first clock after reset_n rises.

REQ-019 The first ce_pix SHALL occur N cycles after reset_n rises.

REQ-020 A reset asserted mid-frame SHALL abort the frame immediately.

REQ-021 After reset, the block SHALL restart at pixel (0,0) with no frame_start for the aborted frame.

Configuration
REQ-022 Macro VIDEO_TIMING_GEN_TESTPAT_EN SHALL control the colour outputs as follows.
- Defined: R, G and B SHALL be 8 vertical colour bars.
- Bar index = min(hcount / (H_ACTIVE/8), 7).
- Bar order: white, yellow, cyan, green, magenta, red, blue, black.
- Each channel SHALL be all-ones or all-zeros.
- All channels SHALL be 0 whenever HBlank or VBlank is 1.
- Undefined: R, G and B SHALL be tied to 0, the ports SHALL remain present, and no pattern logic SHALL be synthesised.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- ce_divider=0 -> ce_pix every 4 clocks; ce_divider=1 -> every 2; ce_divider=7 -> every 8.
- Change ce_divider 0->2 at hcount=100 -> spacing stays 4 until hcount wraps to 0, then becomes 3.
- Default parameters -> HBlank rises at hcount=320; HSync low for hcount 336..367 (32 pulses); hcount wraps after 407.
- Default parameters -> VBlank for vcount 240..261; VSync low for vcount 243..245, edges coincident with hcount=0; frame_start once per 408*262 ce_pix.
- reset_n low at hcount=200, vcount=150 -> outputs take reset values at once; after release, counting resumes from (0,0) with first ce_pix N cycles later.
- With VIDEO_TIMING_GEN_TESTPAT_EN and COLOR_DEPTH=6: hcount=0 -> RGB=3F/3F/3F; hcount=120 -> 00/3F/00; hcount=300 -> 00/00/00; hcount=330 -> 00/00/00. Without the macro: RGB=0 throughout.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: divided pixel clock-enable, h/v counters, syncs, blanks and frame pulse.
// Define VIDEO_TIMING_GEN_TESTPAT_EN to drive 8 vertical colour bars on R/G/B; otherwise they are tied to 0.
module video_timing_gen #(
   parameter int H_ACTIVE    = 320,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 32,
   parameter int H_BP        = 40,
   parameter int V_ACTIVE    = 240,
   parameter int V_FP        = 3,
   parameter int V_SYNC      = 3,
   parameter int V_BP        = 16,
   parameter int COLOR_DEPTH = 6
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [2:0]             ce_divider,
   output logic                   ce_pix,
   output logic [9:0]             hcount,
   output logic [9:0]             vcount,
   output logic                   HSync,
   output logic                   VSync,
   output logic                   HBlank,
   output logic                   VBlank,
   output logic                   DE,
   output logic                   frame_start,
   output logic [COLOR_DEPTH-1:0] R,
   output logic [COLOR_DEPTH-1:0] G,
   output logic [COLOR_DEPTH-1:0] B
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [2:0] div_cnt;
   logic [3:0] n_sel;
   logic [3:0] n_req;
   logic       started;
   logic       div_wrap;
   logic       line_end;

   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       h_blank_next;
   logic       v_blank_next;
   logic       h_sync_next;
   logic       v_sync_next;

   assign n_req    = (ce_divider == 3'd0) ? 4'd4 : ({1'b0, ce_divider} + 4'd1);
   assign div_wrap = ({1'b0, div_cnt} == (n_sel - 4'd1));
   assign line_end = ce_pix && (hcount == H_LAST);

   // The divide ratio only changes while div_cnt is 0, so the counter never overshoots a smaller N.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= 3'd0;
         n_sel   <= 4'd4;
         started <= 1'b0;
         ce_pix  <= 1'b0;
      end else begin
         started <= 1'b1;
         if (!started || line_end) begin
            n_sel <= n_req;
         end
         if (div_wrap) begin
            div_cnt <= 3'd0;
            ce_pix  <= 1'b1;
         end else begin
            div_cnt <= div_cnt + 3'd1;
            ce_pix  <= 1'b0;
         end
      end
   end

   // Decode from the next counter values so the registered flags line up with the counters.
   always_comb begin
      h_next = hcount;
      v_next = vcount;
      if (ce_pix) begin
         if (hcount == H_LAST) begin
            h_next = 10'd0;
            v_next = (vcount == V_LAST) ? 10'd0 : (vcount + 10'd1);
         end else begin
            h_next = hcount + 10'd1;
         end
      end
      h_blank_next = ({1'b0, h_next} >= H_ACT);
      v_blank_next = ({1'b0, v_next} >= V_ACT);
      h_sync_next  = !(({1'b0, h_next} >= HS_BEGIN) && ({1'b0, h_next} < HS_END));
      v_sync_next  = !(({1'b0, v_next} >= VS_BEGIN) && ({1'b0, v_next} < VS_END));
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hcount      <= 10'd0;
         vcount      <= 10'd0;
         HSync       <= 1'b1;
         VSync       <= 1'b1;
         HBlank      <= 1'b0;
         VBlank      <= 1'b0;
         DE          <= 1'b1;
         frame_start <= 1'b0;
      end else if (ce_pix) begin
         hcount      <= h_next;
         vcount      <= v_next;
         HSync       <= h_sync_next;
         VSync       <= v_sync_next;
         HBlank      <= h_blank_next;
         VBlank      <= v_blank_next;
         DE          <= !(h_blank_next || v_blank_next);
         frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
      end else begin
         frame_start <= 1'b0;
      end
   end

`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

   logic [9:0] bar_idx;
   logic [2:0] bar_rgb;

   // Bar indices past 7 (H_ACTIVE not a multiple of 8) fall into the black default.
   always_comb begin
      bar_idx = h_next / 10'(BAR_W);
      bar_rgb = 3'b000;
      if (!h_blank_next && !v_blank_next) begin
         case (bar_idx)
            10'd0:   bar_rgb = 3'b111;
            10'd1:   bar_rgb = 3'b110;
            10'd2:   bar_rgb = 3'b011;
            10'd3:   bar_rgb = 3'b010;
            10'd4:   bar_rgb = 3'b101;
            10'd5:   bar_rgb = 3'b100;
            10'd6:   bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         R <= '0;
         G <= '0;
         B <= '0;
      end else if (ce_pix) begin
         R <= {COLOR_DEPTH{bar_rgb[2]}};
         G <= {COLOR_DEPTH{bar_rgb[1]}};
         B <= {COLOR_DEPTH{bar_rgb[0]}};
      end
   end
`else
   assign R = '0;
   assign G = '0;
   assign B = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-size instance for directed line timing, small instance for whole frames,
// both compared every cycle against a schedule-based raster model.
module tb_video_timing_gen;

   logic       clk_sys;
   logic       reset_n;
   logic [2:0] ce_div_a;
   logic [2:0] ce_div_b;
   logic       cmp_en;
   logic       rand_a;

   logic       ce_pix_a, hsync_a, vsync_a, hblank_a, vblank_a, de_a, fs_a;
   logic [9:0] hcount_a, vcount_a;
   logic [5:0] r_a, g_a, b_a;
   logic       ce_pix_b, hsync_b, vsync_b, hblank_b, vblank_b, de_b, fs_b;
   logic [9:0] hcount_b, vcount_b;
   logic [5:0] r_b, g_b, b_b;

   int checks = 0;
   int errors = 0;
   int frames_b = 0;

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   video_timing_gen dut_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_divider(ce_div_a), .ce_pix(ce_pix_a),
      .hcount(hcount_a), .vcount(vcount_a), .HSync(hsync_a), .VSync(vsync_a),
      .HBlank(hblank_a), .VBlank(vblank_a), .DE(de_a), .frame_start(fs_a),
      .R(r_a), .G(g_a), .B(b_a)
   );

   video_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .COLOR_DEPTH(6)
   ) dut_b (
      .clk_sys(clk_sys), .reset_n(reset_n), .ce_divider(ce_div_b), .ce_pix(ce_pix_b),
      .hcount(hcount_b), .vcount(vcount_b), .HSync(hsync_b), .VSync(vsync_b),
      .HBlank(hblank_b), .VBlank(vblank_b), .DE(de_b), .frame_start(fs_b),
      .R(r_b), .G(g_b), .B(b_b)
   );

   logic [63:0] act_a;
   logic [63:0] act_b;
   assign act_a = {19'd0, ce_pix_a, hcount_a, vcount_a, hsync_a, vsync_a, hblank_a, vblank_a, de_a, fs_a, r_a, g_a, b_a};
   assign act_b = {19'd0, ce_pix_b, hcount_b, vcount_b, hsync_b, vsync_b, hblank_b, vblank_b, de_b, fs_b, r_b, g_b, b_b};

   int ha  [2] = '{320, 16};
   int hfp [2] = '{16, 2};
   int hsy [2] = '{32, 3};
   int hbp [2] = '{40, 3};
   int va  [2] = '{240, 8};
   int vfp [2] = '{3, 1};
   int vsy [2] = '{3, 2};
   int vbp [2] = '{16, 2};
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
   int bar_code [8] = '{7, 6, 3, 2, 5, 4, 1, 0};
`endif

   // Model: cycle index since reset release, cycle of the next expected pulse, current pixel position.
   int m_c [2];
   int m_np [2];
   int m_n [2];
   int m_h [2];
   int m_v [2];
   bit m_adv [2];
   bit m_fs [2];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_c[i] = 0; m_np[i] = 0; m_n[i] = 4; m_h[i] = 0; m_v[i] = 0;
         m_adv[i] = 1'b0; m_fs[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input int i, input logic [2:0] d);
      int nd, ht, vt;
      ht = ha[i] + hfp[i] + hsy[i] + hbp[i];
      vt = va[i] + vfp[i] + vsy[i] + vbp[i];
      nd = (d == 3'd0) ? 4 : int'(d) + 1;
      m_fs[i] = 1'b0;
      if (m_c[i] == 0) begin
         m_n[i]  = nd;
         m_np[i] = nd;
      end else if (m_c[i] == m_np[i]) begin
         m_adv[i] = 1'b1;
         if (m_h[i] == ht - 1) begin
            m_h[i]  = 0;
            m_v[i]  = (m_v[i] + 1) % vt;
            m_n[i]  = nd;
            m_fs[i] = (m_v[i] == 0);
         end else begin
            m_h[i] = m_h[i] + 1;
         end
         m_np[i] = m_c[i] + m_n[i];
      end
      m_c[i] = m_c[i] + 1;
   endtask

   function automatic logic [63:0] exp_word(input int i);
      logic       ce, hs, vs, hb, vb, de;
      logic [2:0] bits;
      logic [5:0] r, g, b;
      ce = (m_c[i] > 0) && (m_c[i] == m_np[i]);
      hb = (m_h[i] >= ha[i]);
      vb = (m_v[i] >= va[i]);
      hs = !((m_h[i] >= ha[i] + hfp[i]) && (m_h[i] < ha[i] + hfp[i] + hsy[i]));
      vs = !((m_v[i] >= va[i] + vfp[i]) && (m_v[i] < va[i] + vfp[i] + vsy[i]));
      de = !(hb || vb);
      bits = 3'b000;
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
      if (m_adv[i] && !hb && !vb) begin
         int bar;
         bar = m_h[i] / (ha[i] / 8);
         if (bar > 7) bar = 7;
         bits = 3'(bar_code[bar]);
      end
`endif
      r = bits[2] ? 6'h3F : 6'h00;
      g = bits[1] ? 6'h3F : 6'h00;
      b = bits[0] ? 6'h3F : 6'h00;
      return {19'd0, ce, 10'(m_h[i]), 10'(m_v[i]), hs, vs, hb, vb, de, m_fs[i], r, g, b};
   endfunction

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         model_reset();
      end else begin
         model_edge(0, ce_div_a);
         model_edge(1, ce_div_b);
      end
   end

   always @(negedge clk_sys) begin
      if (cmp_en) begin
         check_output("cycle_a", act_a, exp_word(0));
         check_output("cycle_b", act_b, exp_word(1));
      end
   end

   // Every frame of the small instance must span exactly 24*13 pixel enables.
   int  pulses_b = 0;
   bit  have_fs_b = 1'b0;
   always @(negedge clk_sys) begin
      if (!reset_n) begin
         pulses_b  = 0;
         have_fs_b = 1'b0;
      end else if (cmp_en) begin
         if (ce_pix_b) pulses_b++;
         if (fs_b) begin
            if (have_fs_b) check_output("frame_period_b", 64'(pulses_b), 64'd312);
            have_fs_b = 1'b1;
            pulses_b  = 0;
            frames_b++;
         end
      end
   end

   task automatic apply_stimulus();
      @(posedge clk_sys);
      #2;
      if ($urandom_range(0, 63) == 0) ce_div_b = 3'($urandom_range(0, 7));
      if (rand_a && $urandom_range(0, 499) == 0) ce_div_a = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_a(input int hv, input bit need_ce, input int vv, input string name);
      bit found;
      found = 1'b0;
      for (int t = 0; t < 5000 && !found; t++) begin
         apply_stimulus();
         if (int'(hcount_a) == hv && (!need_ce || ce_pix_a) && (vv < 0 || int'(vcount_a) == vv)) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: timeout waiting for hcount=%0d, got hcount=%0d", name, hv, hcount_a);
      end
   endtask

   task automatic count_gap(output int g);
      g = 0;
      for (int t = 0; t < 20; t++) begin
         apply_stimulus();
         g++;
         if (ce_pix_a) break;
      end
   endtask

   initial begin
      int first, gap, pix, maxh, hb_first, hs_first, hs_last, hs_lo;
      logic [17:0] rgb0, rgb120, rgb300, rgb330;
      logic [17:0] white, green, black;
      logic [63:0] rst_word;

      white = {6'h3F, 6'h3F, 6'h3F};
      green = {6'h00, 6'h3F, 6'h00};
      black = 18'd0;
      rst_word = {19'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 18'd0};

      reset_n  = 1'b0;
      ce_div_a = 3'd0;
      ce_div_b = 3'($urandom_range(0, 7));
      rand_a   = 1'b0;
      model_reset();
      cmp_en   = 1'b1;
      repeat (3) @(posedge clk_sys);
      #2;
      reset_n = 1'b1;

      first = 0;
      for (int k = 1; k <= 20; k++) begin
         apply_stimulus();
         if (ce_pix_a) begin first = k; break; end
      end
      check_output("first_ce_div0", 64'(first), 64'd4);
      count_gap(gap);
      check_output("gap_div0", 64'(gap), 64'd4);

      // One full line of the default geometry, sampled once per pixel.
      wait_a(0, 1'b1, 1, "line_start");
      pix = 0; maxh = 0; hb_first = -1; hs_first = -1; hs_last = -1; hs_lo = 0;
      rgb0 = '1; rgb120 = '1; rgb300 = '1; rgb330 = '1;
      for (int t = 0; t < 5000; t++) begin
         if (ce_pix_a) begin
            if (t > 0 && hcount_a == 10'd0) break;
            pix++;
            if (int'(hcount_a) > maxh) maxh = int'(hcount_a);
            if (hblank_a && hb_first < 0) hb_first = int'(hcount_a);
            if (!hsync_a) begin
               hs_lo++;
               if (hs_first < 0) hs_first = int'(hcount_a);
               hs_last = int'(hcount_a);
            end
            if (hcount_a == 10'd0)   rgb0   = {r_a, g_a, b_a};
            if (hcount_a == 10'd120) rgb120 = {r_a, g_a, b_a};
            if (hcount_a == 10'd300) rgb300 = {r_a, g_a, b_a};
            if (hcount_a == 10'd330) rgb330 = {r_a, g_a, b_a};
         end
         apply_stimulus();
      end
      check_output("pixels_per_line", 64'(pix), 64'd408);
      check_output("hcount_max", 64'(maxh), 64'd407);
      check_output("hblank_first", 64'(hb_first), 64'd320);
      check_output("hsync_first", 64'(hs_first), 64'd336);
      check_output("hsync_last", 64'(hs_last), 64'd367);
      check_output("hsync_width", 64'(hs_lo), 64'd32);
`ifdef VIDEO_TIMING_GEN_TESTPAT_EN
      check_output("rgb_h0", 64'(rgb0), 64'(white));
      check_output("rgb_h120", 64'(rgb120), 64'(green));
`else
      check_output("rgb_h0", 64'(rgb0), 64'(black));
      check_output("rgb_h120", 64'(rgb120), 64'(black));
`endif
      check_output("rgb_h300", 64'(rgb300), 64'(black));
      check_output("rgb_h330", 64'(rgb330), 64'(black));

      // Divider change mid-line only takes effect after the wrap.
      wait_a(100, 1'b1, -1, "h100");
      ce_div_a = 3'd2;
      count_gap(gap);
      check_output("gap_mid_line", 64'(gap), 64'd4);
      wait_a(406, 1'b1, -1, "h406");
      count_gap(gap);
      check_output("gap_before_wrap", 64'(gap), 64'd4);
      count_gap(gap);
      check_output("gap_after_wrap", 64'(gap), 64'd3);
      check_output("hcount_wrapped", 64'(hcount_a), 64'd0);

      ce_div_a = 3'd1;
      wait_a(407, 1'b1, -1, "wrap_div1");
      count_gap(gap);
      check_output("gap_div1", 64'(gap), 64'd2);
      ce_div_a = 3'd7;
      wait_a(407, 1'b1, -1, "wrap_div7");
      count_gap(gap);
      check_output("gap_div7", 64'(gap), 64'd8);

      // Reset in the middle of a line.
      wait_a(200, 1'b0, -1, "h200");
      reset_n = 1'b0;
      #1;
      check_output("reset_immediate", act_a, rst_word);
      repeat (3) apply_stimulus();
      ce_div_a = 3'd5;
      reset_n  = 1'b1;
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         apply_stimulus();
         if (ce_pix_a) begin first = k; break; end
      end
      check_output("first_ce_after_reset", 64'(first), 64'd6);
      check_output("restart_origin", 64'({vcount_a, hcount_a}), 64'd0);

      rand_a = 1'b1;
      repeat (20000) apply_stimulus();
      check_output("frames_b_seen", 64'(frames_b >= 5), 64'd1);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
